s_ram_arbiter: RTL and testbench



---
 rtl/rc4_pkg.sv | 16 +
 rtl/s_ram_arbiter_picker.sv | 38 +++
 rtl/s_ram_arbiter.sv | 138 +++++++++++++
 tb/tb_s_ram_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 pipeline S RAM access path.
//   arb_state_t  - arbiter FSM states
//   REQ_*        - requester slot assignments on the arbiter request vector
package rc4_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int REQ_INIT    = 0;
    localparam int REQ_SHUFFLE = 1;
    localparam int REQ_DECRYPT = 2;

endpackage

// File: rtl/s_ram_arbiter_picker.sv
// Round-robin picker: purely combinational search for the first asserted
// request starting at the priority pointer and wrapping modulo the
// requester count.
//   req     in   per-requester request levels
//   pointer in   index of the highest-priority requester
//   winner  out  one-hot winning requester (zero when nothing requested)
//   valid   out  high when any request is present
module round_robin_picker #(
    parameter int num_requesters = 3,
    parameter int ptr_width      = $clog2(num_requesters)
) (
    input  logic [num_requesters-1:0] req,
    input  logic [ptr_width-1:0]      pointer,
    output logic [num_requesters-1:0] winner,
    output logic                      valid
);

    always_comb begin
        int                   idx;
        logic [ptr_width-1:0] sel;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        sel    = '0;
        for (int i = 0; i < num_requesters; i++) begin
            idx = int'(pointer) + i;
            if (idx >= num_requesters) begin
                idx = idx - num_requesters;
            end
            sel = ptr_width'(idx);
            if (!valid && req[sel]) begin
                winner[sel] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/s_ram_arbiter.sv
// S RAM arbiter: shares the single-port RC4 state array between the init,
// shuffle and decrypt FSMs. Round-robin grant, held until the owner drops
// its request, followed by one dead cycle before the next owner.
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   req        in   per-requester request levels
//   req_wren   in   per-requester write enables
//   req_addr   in   packed addresses, requester k at [k*aw +: aw]
//   req_data   in   packed write data, requester k at [k*dw +: dw]
//   grant      out  registered one-hot (or zero) grant
//   s_ram_addr out  RAM address from the granted requester, else 0
//   s_ram_data out  RAM write data from the granted requester, else 0
//   s_ram_wren out  RAM write enable, only from the granted requester
//   busy       out  any grant held
import rc4_pkg::*;

module s_ram_arbiter #(
    parameter int num_requesters   = 3,
    parameter int data_width       = 8,
    parameter int s_ram_addr_width = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [num_requesters-1:0]              req,
    input  logic [num_requesters-1:0]              req_wren,
    input  logic [num_requesters*s_ram_addr_width-1:0] req_addr,
    input  logic [num_requesters*data_width-1:0]   req_data,
    output logic [num_requesters-1:0]              grant,
    output logic [s_ram_addr_width-1:0]            s_ram_addr,
    output logic [data_width-1:0]                  s_ram_data,
    output logic                                   s_ram_wren,
    output logic                                   busy
);

    localparam int ptr_width = $clog2(num_requesters);
    typedef logic [ptr_width-1:0] ptr_t;

    arb_state_t                state;
    arb_state_t                state_next;
    logic [num_requesters-1:0] grant_next;
    ptr_t                      pointer;
    ptr_t                      pointer_next;
    ptr_t                      owner;
    ptr_t                      owner_next;
    logic [num_requesters-1:0] winner;
    logic                      winner_valid;
    ptr_t                      winner_idx;

    round_robin_picker #(
        .num_requesters (num_requesters),
        .ptr_width      (ptr_width)
    ) u_picker (
        .req     (req),
        .pointer (pointer),
        .winner  (winner),
        .valid   (winner_valid)
    );

    always_comb begin
        winner_idx = '0;
        for (int k = 0; k < num_requesters; k++) begin
            if (winner[k]) begin
                winner_idx = ptr_t'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant   <= '0;
            pointer <= '0;
            owner   <= '0;
        end else begin
            state   <= state_next;
            grant   <= grant_next;
            pointer <= pointer_next;
            owner   <= owner_next;
        end
    end

    // RELEASE is the dead cycle; the arbitration that IDLE would perform
    // happens on the edge leaving RELEASE so consecutive grants are
    // separated by exactly one all-zero cycle.
    always_comb begin
        state_next   = state;
        grant_next   = grant;
        pointer_next = pointer;
        owner_next   = owner;
        case (state)
            IDLE: begin
                if (winner_valid) begin
                    grant_next = winner;
                    owner_next = winner_idx;
                    state_next = GRANTED;
                end
            end
            GRANTED: begin
                if ((grant & req) == '0) begin
                    grant_next   = '0;
                    pointer_next = (owner == ptr_t'(num_requesters - 1)) ?
                                   '0 : ptr_t'(owner + 1'b1);
                    state_next   = RELEASE;
                end
            end
            RELEASE: begin
                grant_next = '0;
                if (winner_valid) begin
                    grant_next = winner;
                    owner_next = winner_idx;
                    state_next = GRANTED;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                grant_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    // One-hot grant makes the AND-OR mux equivalent to a select and
    // naturally yields zero when nothing is granted.
    always_comb begin
        s_ram_addr = '0;
        s_ram_data = '0;
        for (int k = 0; k < num_requesters; k++) begin
            if (grant[k]) begin
                s_ram_addr = s_ram_addr | req_addr[k*s_ram_addr_width +: s_ram_addr_width];
                s_ram_data = s_ram_data | req_data[k*data_width +: data_width];
            end
        end
        s_ram_wren = |(grant & req_wren);
        busy       = |grant;
    end

endmodule

// File: tb/tb_s_ram_arbiter.sv
// Bench for s_ram_arbiter with three requesters: a table of per-cycle
// vectors followed by hand-written multi-cycle sequences.
import rc4_pkg::*;

module tb_s_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = '0;
    logic [2:0]  req_wren = '0;
    logic [23:0] req_addr = '0;
    logic [23:0] req_data = '0;
    logic [2:0]  grant;
    logic [7:0]  s_ram_addr;
    logic [7:0]  s_ram_data;
    logic        s_ram_wren;
    logic        busy;

    int errors = 0;
    int checks = 0;

    s_ram_arbiter #(
        .num_requesters   (3),
        .data_width       (8),
        .s_ram_addr_width (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_wren   (req_wren),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .grant      (grant),
        .s_ram_addr (s_ram_addr),
        .s_ram_data (s_ram_data),
        .s_ram_wren (s_ram_wren),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert ($onehot0(grant)) else begin
                errors++;
                $display("FAIL onehot: grant=%b required one-hot or zero", grant);
            end
        end
    end

    typedef struct {
        logic [2:0] req;
        logic [2:0] wren;
        logic [2:0] exp_grant;
        logic [7:0] exp_addr;
        logic [7:0] exp_data;
        logic       exp_wren;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n    = 1'b0;
        req      = '0;
        req_wren = '0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] rr_seq[4];

        req_addr[REQ_INIT*8    +: 8] = 8'h11;
        req_addr[REQ_SHUFFLE*8 +: 8] = 8'h2A;
        req_addr[REQ_DECRYPT*8 +: 8] = 8'h33;
        req_data[REQ_INIT*8    +: 8] = 8'h22;
        req_data[REQ_SHUFFLE*8 +: 8] = 8'h5C;
        req_data[REQ_DECRYPT*8 +: 8] = 8'h44;

        //          req     wren    grant   addr   data   wren
        vecs[0]  = '{3'b000, 3'b111, 3'b000, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{3'b010, 3'b010, 3'b010, 8'h2A, 8'h5C, 1'b1};
        vecs[2]  = '{3'b010, 3'b000, 3'b010, 8'h2A, 8'h5C, 1'b0};
        vecs[3]  = '{3'b000, 3'b111, 3'b000, 8'h00, 8'h00, 1'b0};
        vecs[4]  = '{3'b101, 3'b100, 3'b100, 8'h33, 8'h44, 1'b1};
        vecs[5]  = '{3'b101, 3'b001, 3'b100, 8'h33, 8'h44, 1'b0};
        vecs[6]  = '{3'b001, 3'b001, 3'b000, 8'h00, 8'h00, 1'b0};
        vecs[7]  = '{3'b001, 3'b001, 3'b001, 8'h11, 8'h22, 1'b1};
        vecs[8]  = '{3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 1'b0};
        vecs[9]  = '{3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 1'b0};
        vecs[10] = '{3'b101, 3'b101, 3'b100, 8'h33, 8'h44, 1'b1};
        vecs[11] = '{3'b001, 3'b001, 3'b000, 8'h00, 8'h00, 1'b0};
        vecs[12] = '{3'b011, 3'b000, 3'b001, 8'h11, 8'h22, 1'b0};
        vecs[13] = '{3'b010, 3'b010, 3'b000, 8'h00, 8'h00, 1'b0};
        vecs[14] = '{3'b010, 3'b010, 3'b010, 8'h2A, 8'h5C, 1'b1};

        rr_seq[0] = 3'b001;
        rr_seq[1] = 3'b010;
        rr_seq[2] = 3'b100;
        rr_seq[3] = 3'b001;

        // reset state
        do_reset;
        chk("reset.grant", 8'(grant), 8'h00);
        chk("reset.busy",  8'(busy), 8'h00);
        chk("reset.wren",  8'(s_ram_wren), 8'h00);
        chk("reset.addr",  s_ram_addr, 8'h00);
        chk("reset.data",  s_ram_data, 8'h00);

        // table-driven vectors, one clock each
        for (int i = 0; i < 15; i++) begin
            req      = vecs[i].req;
            req_wren = vecs[i].wren;
            tick;
            chk($sformatf("v%0d.grant", i), 8'(grant), 8'(vecs[i].exp_grant));
            chk($sformatf("v%0d.addr", i),  s_ram_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d.data", i),  s_ram_data, vecs[i].exp_data);
            chk($sformatf("v%0d.wren", i),  8'(s_ram_wren), 8'(vecs[i].exp_wren));
            chk($sformatf("v%0d.busy", i),  8'(busy), 8'(vecs[i].exp_grant != 3'b000));
        end

        // round robin with all requests held, each owner dropping briefly
        do_reset;
        req = 3'b111;
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < 4; c++) begin
                tick;
                chk($sformatf("rr%0d.grant", g), 8'(grant), 8'(rr_seq[g]));
                if (c == 3 && g < 3) req = 3'b111 & ~rr_seq[g];
            end
            if (g < 3) begin
                tick;
                chk($sformatf("rr%0d.release", g), 8'(grant), 8'h00);
                chk($sformatf("rr%0d.release_busy", g), 8'(busy), 8'h00);
                req = 3'b111;
            end
        end

        // no preemption, ungranted write blocked, two-cycle handover
        do_reset;
        req      = 3'b001;
        req_wren = 3'b100;
        tick;
        chk("np.grant0", 8'(grant), 8'h01);
        chk("np.wren0",  8'(s_ram_wren), 8'h00);
        req = 3'b101;
        repeat (3) begin
            tick;
            chk("np.grant_hold", 8'(grant), 8'h01);
            chk("np.wren_blocked", 8'(s_ram_wren), 8'h00);
            chk("np.addr_owner", s_ram_addr, 8'h11);
        end
        req = 3'b100;
        tick;
        chk("ho.release", 8'(grant), 8'h00);
        chk("ho.release_wren", 8'(s_ram_wren), 8'h00);
        tick;
        chk("ho.new_grant", 8'(grant), 8'h04);
        chk("ho.new_wren", 8'(s_ram_wren), 8'h01);
        chk("ho.new_addr", s_ram_addr, 8'h33);

        // asynchronous reset mid-grant, pointer returns to 0
        do_reset;
        req      = 3'b010;
        req_wren = 3'b010;
        tick;
        chk("ar.grant1", 8'(grant), 8'h02);
        req = 3'b000;
        tick;
        chk("ar.release", 8'(grant), 8'h00);
        req      = 3'b100;
        req_wren = 3'b100;
        tick;
        chk("ar.grant2", 8'(grant), 8'h04);
        chk("ar.wren2",  8'(s_ram_wren), 8'h01);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar.async_grant", 8'(grant), 8'h00);
        chk("ar.async_wren",  8'(s_ram_wren), 8'h00);
        chk("ar.async_busy",  8'(busy), 8'h00);
        req      = 3'b111;
        req_wren = 3'b111;
        #2;
        rst_n = 1'b1;
        tick;
        chk("ar.first_after_reset", 8'(grant), 8'h01);

        // idle with no requests, write enables alone never reach the RAM
        do_reset;
        req      = 3'b000;
        req_wren = 3'b111;
        for (int c = 0; c < 20; c++) begin
            tick;
            chk($sformatf("idle%0d.grant", c), 8'(grant), 8'h00);
            chk($sformatf("idle%0d.busy", c),  8'(busy), 8'h00);
            chk($sformatf("idle%0d.wren", c),  8'(s_ram_wren), 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
